// File: rtl/clint_pkg.sv
//------------------------------------------------------------------------------
// clint_pkg
// Shared constants for the core-local interrupt/trap controller: CSR
// addresses, FSM state encodings, mcause codes, mstatus bit positions and
// the mstatus update helpers used on trap entry and mret.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clint_pkg;

  localparam int CSR_ADDRESS_WIDTH = 12;

  localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_ADDRESS_WIDTH-1:0] CSR_MTVAL   = 12'h343;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_W_MEPC    = 3'd1;
  localparam logic [STATE_W-1:0] S_W_MSTATUS = 3'd2;
  localparam logic [STATE_W-1:0] S_W_MCAUSE  = 3'd3;
  localparam logic [STATE_W-1:0] S_W_MTVAL   = 3'd4;
  localparam logic [STATE_W-1:0] S_JUMP      = 3'd5;
  localparam logic [STATE_W-1:0] S_R_MSTATUS = 3'd6;
  localparam logic [STATE_W-1:0] S_R_JUMP    = 3'd7;

  localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] MCAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL   = 32'd11;
  localparam logic [31:0] MCAUSE_EXT_IRQ = 32'h8000_000B;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;

  // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as MPP.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r                = s;
    r[MPIE_BIT]      = s[MIE_BIT];
    r[MIE_BIT]       = 1'b0;
    r[MPP_HI:MPP_LO] = 2'b11;
    return r;
  endfunction

  // mret: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r           = s;
    r[MIE_BIT]  = s[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clint_cause_enc.sv
//------------------------------------------------------------------------------
// clint_cause_enc
// Combinational priority encoder for trap requests:
// illegal > ecall > ebreak > mret > external interrupt.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clint_cause_enc
  import clint_pkg::*;
(
  input  logic        valid_i,
  input  logic        illegal_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic        mie_i,
  output logic        req_o,
  output logic        is_mret_o,
  output logic        is_irq_o,
  output logic [31:0] mcause_o
);

  // Pick the highest-priority pending event; sync events need a valid ID slot.
  always_comb begin
    req_o     = 1'b0;
    is_mret_o = 1'b0;
    is_irq_o  = 1'b0;
    mcause_o  = 32'd0;
    if (valid_i && illegal_i) begin
      req_o    = 1'b1;
      mcause_o = MCAUSE_ILLEGAL;
    end else if (valid_i && ecall_i) begin
      req_o    = 1'b1;
      mcause_o = MCAUSE_ECALL;
    end else if (valid_i && ebreak_i) begin
      req_o    = 1'b1;
      mcause_o = MCAUSE_EBREAK;
    end else if (valid_i && mret_i) begin
      req_o     = 1'b1;
      is_mret_o = 1'b1;
    end else if (irq_i && mie_i) begin
      req_o    = 1'b1;
      is_irq_o = 1'b1;
      mcause_o = MCAUSE_EXT_IRQ;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clint.sv
//------------------------------------------------------------------------------
// clint
// Core-local interrupt/trap controller. Stalls IF/ID on a trap or mret,
// sequences mepc/mstatus/mcause (optionally mtval) writes into the CSR block
// and then redirects the PC to mtvec or mepc.
// Build option: CLINT_MTVAL_EN adds a W_MTVAL state writing the faulting
// instruction word for illegal instructions (0 for other causes).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clint
  import clint_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid_i,
  input  logic [31:0]                  id_pc_i,
  input  logic [31:0]                  id_inst_i,
  input  logic                         id_ecall_i,
  input  logic                         id_ebreak_i,
  input  logic                         id_illegal_i,
  input  logic                         id_mret_i,
  input  logic                         ex_jump_i,
  input  logic [31:0]                  ex_jump_addr_i,
  input  logic                         ex_csr_we_i,
  input  logic                         irq_i,
  input  logic [31:0]                  csr_mtvec_i,
  input  logic [31:0]                  csr_mepc_i,
  input  logic [31:0]                  csr_mstatus_i,
  output logic                         csr_we_o,
  output logic [CSR_ADDRESS_WIDTH-1:0] csr_waddr_o,
  output logic [31:0]                  csr_wdata_o,
  output logic                         hold_o,
  output logic                         jump_o,
  output logic [31:0]                  jump_addr_o
);

  logic [STATE_W-1:0]           state_q, state_d;
  logic [31:0]                  cause_q;
  logic                         csr_we_q, csr_we_d;
  logic [CSR_ADDRESS_WIDTH-1:0] csr_waddr_q, csr_waddr_d;
  logic [31:0]                  csr_wdata_q, csr_wdata_d;

  logic        req;
  logic        is_mret;
  logic        is_irq;
  logic [31:0] mcause;
  logic        start;
  logic [31:0] ret_pc;

  clint_cause_enc u_cause_enc (
    .valid_i   (id_valid_i),
    .illegal_i (id_illegal_i),
    .ecall_i   (id_ecall_i),
    .ebreak_i  (id_ebreak_i),
    .mret_i    (id_mret_i),
    .irq_i     (irq_i),
    .mie_i     (csr_mstatus_i[MIE_BIT]),
    .req_o     (req),
    .is_mret_o (is_mret),
    .is_irq_o  (is_irq),
    .mcause_o  (mcause)
  );

  // A request waits while EX owns the CSR write port so no clint write is lost.
  assign start  = (state_q == S_IDLE) && req && !ex_csr_we_i;
  assign ret_pc = (is_irq && ex_jump_i) ? ex_jump_addr_i : id_pc_i;

`ifdef CLINT_MTVAL_EN
  logic [31:0] inst_q;

  // Capture the instruction word at trap entry for mtval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     inst_q <= 32'd0;
    else if (start) inst_q <= id_inst_i;
  end
`else
  logic unused_inst;
  assign unused_inst = ^id_inst_i;
`endif

  logic unused_mtvec_lo;
  assign unused_mtvec_lo = ^csr_mtvec_i[1:0];

  // State register plus registered CSR write port and latched cause.
  // The return PC needs no separate latch: it is written to mepc in the
  // very next cycle and is captured directly into csr_wdata_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cause_q     <= 32'd0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      csr_we_q    <= csr_we_d;
      csr_waddr_q <= csr_waddr_d;
      csr_wdata_q <= csr_wdata_d;
      if (start) cause_q <= mcause;
    end
  end

  // Next-state sequencing for trap entry and mret.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = is_mret ? S_R_MSTATUS : S_W_MEPC;
      S_W_MEPC:    state_d = S_W_MSTATUS;
      S_W_MSTATUS: state_d = S_W_MCAUSE;
`ifdef CLINT_MTVAL_EN
      S_W_MCAUSE:  state_d = S_W_MTVAL;
      S_W_MTVAL:   state_d = S_JUMP;
`else
      S_W_MCAUSE:  state_d = S_JUMP;
`endif
      S_JUMP:      state_d = S_IDLE;
      S_R_MSTATUS: state_d = S_R_JUMP;
      S_R_JUMP:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs: the write for the next state is prepared here and registered,
  // hold/jump are decoded from the current state.
  always_comb begin
    csr_we_d    = 1'b0;
    csr_waddr_d = '0;
    csr_wdata_d = 32'd0;
    hold_o      = (state_q != S_IDLE) || req;
    jump_o      = 1'b0;
    jump_addr_o = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          csr_we_d = 1'b1;
          if (is_mret) begin
            csr_waddr_d = CSR_MSTATUS;
            csr_wdata_d = mret_mstatus(csr_mstatus_i);
          end else begin
            csr_waddr_d = CSR_MEPC;
            csr_wdata_d = ret_pc;
          end
        end
      end
      S_W_MEPC: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MSTATUS;
        csr_wdata_d = trap_mstatus(csr_mstatus_i);
      end
      S_W_MSTATUS: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MCAUSE;
        csr_wdata_d = cause_q;
      end
`ifdef CLINT_MTVAL_EN
      S_W_MCAUSE: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MTVAL;
        csr_wdata_d = (cause_q == MCAUSE_ILLEGAL) ? inst_q : 32'd0;
      end
`endif
      S_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = {csr_mtvec_i[31:2], 2'b00};
      end
      S_R_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = csr_mepc_i;
      end
      default: ;
    endcase
  end

  assign csr_we_o    = csr_we_q;
  assign csr_waddr_o = csr_waddr_q;
  assign csr_wdata_o = csr_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_clint.sv
//------------------------------------------------------------------------------
// tb_clint
// Directed, table-driven bench for clint: one record per cycle holds the
// inputs for that cycle and the outputs expected at mid-cycle.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clint;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_inst_i;
  logic        id_ecall_i, id_ebreak_i, id_illegal_i, id_mret_i;
  logic        ex_jump_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_csr_we_i;
  logic        irq_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        hold_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clint dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid_i),
    .id_pc_i        (id_pc_i),
    .id_inst_i      (id_inst_i),
    .id_ecall_i     (id_ecall_i),
    .id_ebreak_i    (id_ebreak_i),
    .id_illegal_i   (id_illegal_i),
    .id_mret_i      (id_mret_i),
    .ex_jump_i      (ex_jump_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .ex_csr_we_i    (ex_csr_we_i),
    .irq_i          (irq_i),
    .csr_mtvec_i    (csr_mtvec_i),
    .csr_mepc_i     (csr_mepc_i),
    .csr_mstatus_i  (csr_mstatus_i),
    .csr_we_o       (csr_we_o),
    .csr_waddr_o    (csr_waddr_o),
    .csr_wdata_o    (csr_wdata_o),
    .hold_o         (hold_o),
    .jump_o         (jump_o),
    .jump_addr_o    (jump_addr_o)
  );

  // evt bits: {illegal, ecall, ebreak, mret, irq}
  typedef struct {
    string       name;
    logic [31:0] valid, pc, inst, evt, exj, exja, excsr;
    logic [31:0] mtvec, mepc, mstatus;
    logic [31:0] we, waddr, wdata, hold, jump, jaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name,
                     input logic [31:0] valid, pc, inst, evt, exj, exja, excsr,
                     input logic [31:0] mtvec, mepc, mstatus,
                     input logic [31:0] we, waddr, wdata, hold, jump, jaddr);
    vec_t v;
    v.name = name;  v.valid = valid; v.pc = pc; v.inst = inst; v.evt = evt;
    v.exj = exj;    v.exja = exja;   v.excsr = excsr;
    v.mtvec = mtvec; v.mepc = mepc;  v.mstatus = mstatus;
    v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.hold = hold; v.jump = jump; v.jaddr = jaddr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid_i     = v.valid[0];
    id_pc_i        = v.pc;
    id_inst_i      = v.inst;
    id_illegal_i   = v.evt[4];
    id_ecall_i     = v.evt[3];
    id_ebreak_i    = v.evt[2];
    id_mret_i      = v.evt[1];
    irq_i          = v.evt[0];
    ex_jump_i      = v.exj[0];
    ex_jump_addr_i = v.exja;
    ex_csr_we_i    = v.excsr[0];
    csr_mtvec_i    = v.mtvec;
    csr_mepc_i     = v.mepc;
    csr_mstatus_i  = v.mstatus;
  endtask

  task automatic clear_inputs();
    id_valid_i = 0; id_pc_i = 0; id_inst_i = 0;
    id_ecall_i = 0; id_ebreak_i = 0; id_illegal_i = 0; id_mret_i = 0;
    ex_jump_i = 0; ex_jump_addr_i = 0; ex_csr_we_i = 0; irq_i = 0;
    csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
  endtask

  task automatic check_vec(input vec_t v);
    chk({v.name, " we"},   {31'd0, csr_we_o}, v.we);
    chk({v.name, " hold"}, {31'd0, hold_o},   v.hold);
    chk({v.name, " jump"}, {31'd0, jump_o},   v.jump);
    if (v.we[0]) begin
      chk({v.name, " waddr"}, {20'd0, csr_waddr_o}, v.waddr);
      chk({v.name, " wdata"}, csr_wdata_o, v.wdata);
    end
    if (v.jump[0]) chk({v.name, " jaddr"}, jump_addr_o, v.jaddr);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, " we"},    {31'd0, csr_we_o}, 0);
    chk({name, " waddr"}, {20'd0, csr_waddr_o}, 0);
    chk({name, " wdata"}, csr_wdata_o, 0);
    chk({name, " hold"},  {31'd0, hold_o}, 0);
    chk({name, " jump"},  {31'd0, jump_o}, 0);
    chk({name, " jaddr"}, jump_addr_o, 0);
  endtask

  initial begin
    //   name          vld pc      inst        evt      exj exja    csr mtvec   mepc    mstatus         we waddr   wdata         hold jmp jaddr
    // ecall -> mepc/mstatus/mcause, jump to mtvec
    add("ecall c0",     1, 'h100, 'h73,       'b01000, 0, 0,      0, 'h200, 0,      'h8,            0, 0,      0,            1, 0, 0);
    add("ecall c1",     0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            1, 'h341,  'h100,        1, 0, 0);
    add("ecall c2",     0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            1, 'h300,  'h1880,       1, 0, 0);
    add("ecall c3",     0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            1, 'h342,  11,           1, 0, 0);
`ifdef CLINT_MTVAL_EN
    add("ecall mtval",  0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            1, 'h343,  0,            1, 0, 0);
`endif
    add("ecall jump",   0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            0, 0,      0,            1, 1, 'h200);
    add("ecall idle",   0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            0, 0,      0,            0, 0, 0);
    // mret -> mstatus restore, jump to mepc
    add("mret c0",      1, 'h104, 'h30200073, 'b00010, 0, 0,      0, 'h200, 'h104,  'h1880,         0, 0,      0,            1, 0, 0);
    add("mret c1",      0, 0,     0,          0,       0, 0,      0, 'h200, 'h104,  'h1880,         1, 'h300,  'h1888,       1, 0, 0);
    add("mret jump",    0, 0,     0,          0,       0, 0,      0, 'h200, 'h104,  'h1880,         0, 0,      0,            1, 1, 'h104);
    add("mret idle",    0, 0,     0,          0,       0, 0,      0, 'h200, 'h104,  'h1880,         0, 0,      0,            0, 0, 0);
    // interrupt while EX redirects: return to the EX target; irq held but ignored mid-sequence
    add("irq c0",       0, 'h50,  0,          'b00001, 1, 'h300,  0, 'h403, 0,      'h8,            0, 0,      0,            1, 0, 0);
    add("irq c1",       0, 0,     0,          'b00001, 0, 0,      0, 'h403, 0,      'h8,            1, 'h341,  'h300,        1, 0, 0);
    add("irq c2",       0, 0,     0,          'b00001, 0, 0,      0, 'h403, 0,      'h8,            1, 'h300,  'h1880,       1, 0, 0);
    add("irq c3",       0, 0,     0,          'b00001, 0, 0,      0, 'h403, 0,      'h8,            1, 'h342,  'h8000000B,   1, 0, 0);
`ifdef CLINT_MTVAL_EN
    add("irq mtval",    0, 0,     0,          0,       0, 0,      0, 'h403, 0,      'h8,            1, 'h343,  0,            1, 0, 0);
`endif
    add("irq jump",     0, 0,     0,          0,       0, 0,      0, 'h403, 0,      'h8,            0, 0,      0,            1, 1, 'h400);
    add("irq idle",     0, 0,     0,          0,       0, 0,      0, 'h403, 0,      'h8,            0, 0,      0,            0, 0, 0);
    // interrupt masked by MIE=0, and ecall without a valid ID slot
    add("irq mie0 a",   0, 'h60,  0,          'b00001, 0, 0,      0, 'h200, 0,      'h80,           0, 0,      0,            0, 0, 0);
    add("irq mie0 b",   0, 'h60,  0,          'b00001, 0, 0,      0, 'h200, 0,      'h80,           0, 0,      0,            0, 0, 0);
    add("ecall novld",  0, 'h70,  0,          'b01000, 0, 0,      0, 'h200, 0,      'h8,            0, 0,      0,            0, 0, 0);
    // ebreak wins over mret; MIE=0 gives MPIE=0
    add("ebrk c0",      1, 'h80,  'h100073,   'b00110, 0, 0,      0, 'h200, 0,      0,              0, 0,      0,            1, 0, 0);
    add("ebrk c1",      0, 0,     0,          0,       0, 0,      0, 'h200, 0,      0,              1, 'h341,  'h80,         1, 0, 0);
    add("ebrk c2",      0, 0,     0,          0,       0, 0,      0, 'h200, 0,      0,              1, 'h300,  'h1800,       1, 0, 0);
    add("ebrk c3",      0, 0,     0,          0,       0, 0,      0, 'h200, 0,      0,              1, 'h342,  3,            1, 0, 0);
`ifdef CLINT_MTVAL_EN
    add("ebrk mtval",   0, 0,     0,          0,       0, 0,      0, 'h200, 0,      0,              1, 'h343,  0,            1, 0, 0);
`endif
    add("ebrk jump",    0, 0,     0,          0,       0, 0,      0, 'h200, 0,      0,              0, 0,      0,            1, 1, 'h200);
    add("ebrk idle",    0, 0,     0,          0,       0, 0,      0, 'h200, 0,      0,              0, 0,      0,            0, 0, 0);
    // illegal + irq while EX writes a CSR for two cycles: hold, no writes, then illegal wins
    add("ill gate0",    1, 'h40,  'hFFFFFFFF, 'b10001, 0, 0,      1, 'h200, 0,      'h8,            0, 0,      0,            1, 0, 0);
    add("ill gate1",    1, 'h40,  'hFFFFFFFF, 'b10001, 0, 0,      1, 'h200, 0,      'h8,            0, 0,      0,            1, 0, 0);
    add("ill c0",       1, 'h40,  'hFFFFFFFF, 'b10001, 0, 0,      0, 'h200, 0,      'h8,            0, 0,      0,            1, 0, 0);
    add("ill c1",       0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            1, 'h341,  'h40,         1, 0, 0);
    add("ill c2",       0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            1, 'h300,  'h1880,       1, 0, 0);
    add("ill c3",       0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            1, 'h342,  2,            1, 0, 0);
`ifdef CLINT_MTVAL_EN
    add("ill mtval",    0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            1, 'h343,  'hFFFFFFFF,   1, 0, 0);
`endif
    add("ill jump",     0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            0, 0,      0,            1, 1, 'h200);
    add("ill idle",     0, 0,     0,          0,       0, 0,      0, 'h200, 0,      'h8,            0, 0,      0,            0, 0, 0);

    // reset state
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check_vec(vecs[i]);
    end

    // asynchronous reset in the middle of W_MSTATUS: only mepc gets committed
    @(posedge clk); #1;
    clear_inputs();
    id_valid_i = 1; id_pc_i = 32'h100; id_ecall_i = 1;
    csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8;
    @(negedge clk);
    chk("rstmid c0 hold", {31'd0, hold_o}, 1);
    @(posedge clk); #1;
    id_valid_i = 0; id_ecall_i = 0;
    @(negedge clk);
    chk("rstmid c1 we", {31'd0, csr_we_o}, 1);
    chk("rstmid c1 waddr", {20'd0, csr_waddr_o}, 'h341);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid c2 waddr", {20'd0, csr_waddr_o}, 'h300);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rstmid async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rstmid after%0d we", k), {31'd0, csr_we_o}, 0);
      chk($sformatf("rstmid after%0d hold", k), {31'd0, hold_o}, 0);
      chk($sformatf("rstmid after%0d jump", k), {31'd0, jump_o}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clint.md
# clint

Core-local interrupt/trap controller for the pipelined RV32I core. Detects synchronous exceptions (ecall, ebreak, illegal), mret and the external interrupt; stalls the pipeline; sequences mepc/mstatus/mcause writes into the csr block over its dedicated clint write port; then redirects the PC to mtvec or mepc. It drives csr_we_clint/csr_waddr_clint/csr_wdata_clint and consumes csr_mtvec/csr_mepc/csr_mstatus.

## Interface
- No parameters; address width is `CSR_ADDRESS_WIDTH from defines.v.
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- id_valid_i  in  1  ID stage holds a valid instruction
- id_pc_i  in  32  PC of the instruction in ID
- id_inst_i  in  32  instruction word in ID
- id_ecall_i / id_ebreak_i / id_illegal_i / id_mret_i  in  1 each  decoded in ID
- ex_jump_i  in  1  EX redirects this cycle
- ex_jump_addr_i  in  32  EX redirect target
- ex_csr_we_i  in  1  EX is writing a CSR this cycle
- irq_i  in  1  external interrupt, level, already synchronised
- csr_mtvec_i / csr_mepc_i / csr_mstatus_i  in  32 each  current CSR values
- csr_we_o  out  1  to csr_we_clint
- csr_waddr_o  out  `CSR_ADDRESS_WIDTH  to csr_waddr_clint
- csr_wdata_o  out  32  to csr_wdata_clint
- hold_o  out  1  stall IF/ID (EX and later drain)
- jump_o  out  1  PC redirect strobe
- jump_addr_o  out  32  redirect target

## Operation
- States: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, [W_MTVAL], JUMP, R_MSTATUS (mret), R_JUMP.
- Request in IDLE, priority: illegal > ecall > ebreak > mret > interrupt. Sync events need id_valid_i. Interrupt needs irq_i and csr_mstatus_i[3] (MIE)=1.
- Start gated: if ex_csr_we_i=1, stay IDLE with hold_o=1 (csr gives EX port priority; no clint write may be lost).
- On start latch cause, return PC, inst word. Return PC: exception -> id_pc_i; interrupt -> ex_jump_addr_i if ex_jump_i else id_pc_i.
- mcause: illegal 2, ebreak 3, ecall 11, external interrupt 32'h8000_000B.
- Trap mstatus = csr_mstatus_i with [7] MPIE<=[3], [3] MIE<=0, [12:11] MPP<=2'b11; other bits kept.
- mret mstatus: [3]<=[7], [7]<=1; others kept.
- JUMP: jump_addr_o = {csr_mtvec_i[31:2],2'b00} (direct mode only). R_JUMP: jump_addr_o = csr_mepc_i.
- Requests seen outside IDLE are ignored; re-evaluated in IDLE.

## Timing
- Reset: state IDLE; csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, hold_o=0, jump_o=0, jump_addr_o=0.
- Cycle 0 (IDLE, request accepted): hold_o=1 combinationally; no write.
- Trap: c1 W_MEPC, c2 W_MSTATUS, c3 W_MCAUSE, [c4 W_MTVAL], then JUMP (jump_o=1 one cycle), then IDLE. Latency 5 cycles (6 with MTVAL) from detect to redirect.
- mret: c1 R_MSTATUS write, c2 R_JUMP, then IDLE.
- csr_we_o high exactly one cycle per write state; address/data are registered outputs valid in that state.
- hold_o high from detect through JUMP/R_JUMP inclusive; low in following IDLE.
- mstatus computed from csr_mstatus_i sampled in the write state.
- Reset mid-sequence: immediate async return to IDLE, outputs zero; already committed CSR writes stand.

## Configuration
- CLINT_MTVAL_EN defined: W_MTVAL state after W_MCAUSE writes mtval = latched instruction word for illegal, 0 otherwise.
- Undefined: no W_MTVAL state, mtval never written, trap latency 5.

## Structure
- defines.v: CSR addresses (existing), FSM state encodings, mcause codes, mstatus bit indices (MIE 3, MPIE 7, MPP 12:11).
- One natural sub-module: clint_cause_enc, combinational priority encoder producing request-valid, mcause and is-mret.

## Test plan
- ecall at id_pc_i=0x100, mtvec=0x200, mstatus=0x8: writes mepc=0x100, mstatus=0x1880, mcause=11; jump_o to 0x200 at c4; hold_o c0-c4.
- mret with mepc=0x104, mstatus=0x1880: writes mstatus=0x1888; jump_o to 0x104 at c2.
- irq_i=1, MIE=1, ex_jump_i=1 to 0x300: mepc=0x300, mcause=0x8000000B. With MIE=0: no action, hold_o=0.
- Illegal and irq same cycle, ex_csr_we_i=1 for 2 cycles: hold_o=1, no writes until ex_csr_we_i drops; then mcause=2.
- rst_n low during W_MSTATUS: outputs zero immediately, IDLE; only mepc committed.
- CLINT_MTVAL_EN: illegal inst 0xFFFFFFFF writes mtval=0xFFFFFFFF at c4, jump at c5.
